// File: rtl/ssi_pkg.sv
// ssi_pkg: shared constants, FSM state type and counter-width helper for the ssi receiver
package ssi_pkg;
   localparam int LANES = 4;
   typedef enum logic {IDLE, SHIFT} state_t;
   function automatic int cnt_w(input int dw);
      return $clog2(dw + 1);
   endfunction
endpackage

// File: rtl/ssi_sync.sv
// ssi_sync: two-flop synchroniser for ssi_clk/fss/xdat plus ssi_clk rising-edge detect
// ports: clk, rst in; ssi_clk, ssi_fss, ssi_xdat raw link in; clk_edge, fss_s, xdat_s synchronised out
module ssi_sync import ssi_pkg::*; (
   input  logic             clk,
   input  logic             rst,
   input  logic             ssi_clk,
   input  logic             ssi_fss,
   input  logic [LANES-1:0] ssi_xdat,
   output logic             clk_edge,
   output logic             fss_s,
   output logic [LANES-1:0] xdat_s
);
   logic [LANES+1:0] r_s1, r_s2;
   logic             r_clk_d;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_clk_d <= 1'b0;
      end else begin
         r_s1    <= {ssi_clk, ssi_fss, ssi_xdat};
         r_s2    <= r_s1;
         r_clk_d <= r_s2[LANES+1];
      end
   end
   assign clk_edge = r_s2[LANES+1] & ~r_clk_d;
   assign fss_s    = r_s2[LANES];
   assign xdat_s   = r_s2[LANES-1:0];
endmodule

// File: rtl/ssi_rx.sv
// ssi_rx: 4-lane synchronous serial receiver, one DW-bit word per lane per frame, valid/ready output
// ports: clk, rst; ssi_clk, ssi_fss, ssi_xdat link in; rx_data/rx_valid/rx_ready frame out;
//        frm_err (framing/timeout pulse), overflow (dropped frame pulse), frm_cnt (accepted frames)
module ssi_rx import ssi_pkg::*; #(
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ssi_clk,
   input  logic                ssi_fss,
   input  logic [LANES-1:0]    ssi_xdat,
   output logic [LANES*DW-1:0] rx_data,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic                frm_err,
   output logic                overflow,
   output logic [15:0]         frm_cnt
);
   localparam int CW = cnt_w(DW);
   state_t              r_state, w_next;
   logic                w_edge, w_fss;
   logic [LANES-1:0]    w_xdat;
   logic [LANES*DW-1:0] r_sh, w_sh;
   logic [CW-1:0]       r_cnt;
   logic [15:0]         r_tmo;
   logic                w_shift, w_done, w_err, w_load;
   ssi_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .ssi_clk  (ssi_clk),
      .ssi_fss  (ssi_fss),
      .ssi_xdat (ssi_xdat),
      .clk_edge (w_edge),
      .fss_s    (w_fss),
      .xdat_s   (w_xdat)
   );
   // w_sh already contains the bit of the current edge, so a completed frame loads straight from it
   always_comb begin
      w_sh = r_sh;
      for (int l = 0; l < LANES; l++) w_sh[l*DW +: DW] = {r_sh[l*DW +: DW-1], w_xdat[l]};
   end
   always_comb begin
      w_next  = r_state;
      w_err   = 1'b0;
      w_done  = 1'b0;
      w_shift = w_edge & (r_state == SHIFT | w_fss);
      if (r_state == IDLE) w_next = (w_edge & w_fss) ? SHIFT : IDLE;
      else if (w_edge) begin
         w_err  = w_fss;
         w_done = ~w_fss & (r_cnt == CW'(DW-1));
         w_next = w_done ? IDLE : SHIFT;
      end else if (r_tmo == 16'(TIMEOUT-1)) begin
         w_err  = 1'b1;
         w_next = IDLE;
      end
   end
   assign w_load = w_done & (~rx_valid | rx_ready);
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh     <= '0;
         r_cnt    <= '0;
         r_tmo    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         frm_err  <= 1'b0;
         overflow <= 1'b0;
         frm_cnt  <= '0;
      end else begin
         if (w_shift) begin
            r_sh  <= w_sh;
            r_cnt <= w_fss ? CW'(1) : r_cnt + 1'b1;
         end
         r_tmo    <= (r_state == IDLE | w_edge) ? '0 : r_tmo + 1'b1;
         frm_err  <= w_err;
         overflow <= w_done & ~w_load;
         if (w_load) begin
            rx_data <= w_sh;
            frm_cnt <= frm_cnt + 1'b1;
         end
         rx_valid <= w_load | (rx_valid & ~rx_ready);
      end
   end
endmodule

// File: tb/tb_ssi_rx.sv
// tb_ssi_rx: self-checking bench for ssi_rx with vector table, corner sequences and random model check
module tb_ssi_rx;
   logic        clk = 1'b0, rst = 1'b1, ssi_clk = 1'b0, ssi_fss = 1'b0, rx_ready = 1'b0;
   logic [3:0]  ssi_xdat = '0;
   logic [63:0] rx_data;
   logic        rx_valid, frm_err, overflow;
   logic [15:0] frm_cnt;
   int vectors = 0, miscompares = 0;
   int n_err = 0, n_ovf = 0, n_val = 0;
   logic [63:0] got[$];
   logic [63:0] exp_q[$];
   logic        m_valid = 1'b0;
   logic [63:0] m_data = '0;
   int m_cnt = 0, m_ovf = 0, m_err = 0;
   typedef struct {
      logic [15:0] l0, l1, l2, l3;
      logic [63:0] exp;
   } vec_t;
   vec_t tbl[4];
   always #5 clk = ~clk;
   ssi_rx #(.DW(16), .TIMEOUT(255)) dut (
      .clk      (clk),
      .rst      (rst),
      .ssi_clk  (ssi_clk),
      .ssi_fss  (ssi_fss),
      .ssi_xdat (ssi_xdat),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frm_err  (frm_err),
      .overflow (overflow),
      .frm_cnt  (frm_cnt)
   );
   always @(negedge clk) begin
      if (!rst) begin
         n_err += int'(frm_err);
         n_ovf += int'(overflow);
         n_val += int'(rx_valid & rx_ready);
         if (rx_valid & rx_ready) got.push_back(rx_data);
      end
   end
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send_bit(input logic f, input logic [3:0] x);
      ssi_clk = 1'b0;
      ssi_fss = f;
      ssi_xdat = x;
      tick(4);
      ssi_clk = 1'b1;
      tick(4);
   endtask
   task automatic send_bits(input logic [63:0] fr, input int n);
      for (int b = 0; b < n; b++) begin
         logic [3:0] x;
         for (int l = 0; l < 4; l++) x[l] = fr[l*16 + 15 - b];
         send_bit(b == 0, x);
      end
   endtask
   task automatic set_ready(input logic r);
      rx_ready = r;
      if (r && m_valid) begin
         exp_q.push_back(m_data);
         m_valid = 1'b0;
      end
   endtask
   task automatic send_frame(input logic [63:0] fr);
      send_bits(fr, 16);
      if (m_valid) m_ovf++;
      else begin
         m_cnt++;
         if (rx_ready) exp_q.push_back(fr);
         else begin
            m_valid = 1'b1;
            m_data = fr;
         end
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      ssi_clk = 1'b0;
      ssi_fss = 1'b0;
      tick(3);
      rst = 1'b0;
      n_err = 0; n_ovf = 0; n_val = 0;
      got.delete(); exp_q.delete();
      m_valid = 1'b0; m_cnt = 0; m_ovf = 0; m_err = 0;
   endtask
   task automatic compare_model(input string name);
      set_ready(1'b1);
      tick(10);
      check({name, "_nfrm"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) check({name, "_frame"}, got[i], exp_q[i]);
      check({name, "_err"}, 64'(n_err), 64'(m_err));
      check({name, "_ovf"}, 64'(n_ovf), 64'(m_ovf));
      check({name, "_cnt"}, 64'(frm_cnt), 64'(m_cnt));
   endtask
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      logic [63:0] last;
      tbl[0] = '{16'hA5A5, 16'h1234, 16'hFFFF, 16'h0001, 64'h0001_FFFF_1234_A5A5};
      tbl[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h8000, 64'h8000_0000_0000_0000};
      tbl[2] = '{16'h0001, 16'h8001, 16'h7FFE, 16'hC3C3, 64'hC3C3_7FFE_8001_0001};
      tbl[3] = '{16'hDEAD, 16'hBEEF, 16'h0F0F, 16'hF0F0, 64'hF0F0_0F0F_BEEF_DEAD};
      do_reset();
      check("rst_data", rx_data, 64'h0);
      check("rst_valid", 64'(rx_valid), 64'h0);
      check("rst_cnt", 64'(frm_cnt), 64'h0);
      check("rst_err", 64'(frm_err), 64'h0);
      check("rst_ovf", 64'(overflow), 64'h0);
      set_ready(1'b1);
      for (int i = 0; i < 4; i++) begin
         send_frame({tbl[i].l3, tbl[i].l2, tbl[i].l1, tbl[i].l0});
         tick(4);
         last = (got.size() > 0) ? got[got.size()-1] : 64'hX;
         check("tbl_data", last, tbl[i].exp);
         check("tbl_cnt", 64'(frm_cnt), 64'(i + 1));
      end
      check("tbl_valid_cycles", 64'(n_val), 64'd4);
      check("tbl_err", 64'(n_err), 64'd0);
      check("tbl_ovf", 64'(n_ovf), 64'd0);
      do_reset();
      set_ready(1'b0);
      send_frame(64'h1111_2222_3333_4444);
      send_frame(64'h5555_6666_7777_8888);
      tick(4);
      check("hold_ovf", 64'(n_ovf), 64'd1);
      check("hold_data", rx_data, 64'h1111_2222_3333_4444);
      check("hold_valid", 64'(rx_valid), 64'd1);
      check("hold_cnt", 64'(frm_cnt), 64'd1);
      rx_ready = 1'b1;
      tick(2);
      check("drain_valid", 64'(rx_valid), 64'd0);
      check("drain_cnt", 64'(frm_cnt), 64'd1);
      check("drain_nfrm", 64'(got.size()), 64'd1);
      do_reset();
      set_ready(1'b1);
      send_bits(64'hFFFF_0000_FFFF_0000, 8);
      m_err++;
      send_frame(64'h1357_2468_9ABC_5A5A);
      tick(4);
      check("resync_err", 64'(n_err), 64'd1);
      last = (got.size() > 0) ? got[got.size()-1] : 64'hX;
      check("resync_lane0", 64'(last[15:0]), 64'h5A5A);
      compare_model("resync");
      do_reset();
      set_ready(1'b1);
      send_bits(64'hAAAA_5555_AAAA_5555, 5);
      tick(240);
      check("tmo_early", 64'(n_err), 64'd0);
      tick(60);
      check("tmo_err", 64'(n_err), 64'd1);
      check("tmo_novalid", 64'(n_val), 64'd0);
      m_err++;
      send_frame(64'h0F0F_1E1E_2D2D_3C3C);
      compare_model("tmo");
      do_reset();
      set_ready(1'b1);
      send_bits(64'h1234_5678_9ABC_DEF0, 8);
      do_reset();
      set_ready(1'b1);
      send_frame(64'hCAFE_F00D_0BAD_BEEF);
      tick(4);
      check("rstmid_nval", 64'(n_val), 64'd1);
      check("rstmid_cnt", 64'(frm_cnt), 64'd1);
      compare_model("rstmid");
      do_reset();
      set_ready(1'b1);
      force dut.frm_cnt = 16'hFFFF;
      tick(1);
      release dut.frm_cnt;
      send_frame(64'h0001_0002_0003_0004);
      tick(4);
      check("wrap_cnt", 64'(frm_cnt), 64'h0);
      do_reset();
      for (int i = 0; i < 30; i++) begin
         set_ready(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            send_bits({$urandom, $urandom}, $urandom_range(1, 15));
            m_err++;
         end
         send_frame({$urandom, $urandom});
         tick($urandom_range(0, 20));
      end
      compare_model("rand");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
